axis_fifo_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr_ctrl.sv | 75 +++++++
 rtl/axis_fifo_param.sv | 80 ++++++++
 tb/tb_axis_fifo_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised AXIS FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH = 45;
    localparam int FIFO_DEPTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, flag and watermark control for axis_fifo_param.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int AW        = clog2(DEPTH),
    parameter int LW        = AW + 1
) (
    input  logic          axis_clk,
    input  logic          axi_reset,
    input  logic          flush,
    input  logic          w_vld,
    input  logic          r_rdy,
    output logic          w_rdy,
    output logic          r_vld,
    output logic          w_cyc,
    output logic          r_cyc,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [LW-1:0] max_level
);

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          full;
    logic          empty;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign w_rdy = !full && !flush;
    assign r_vld = !empty && !flush;
    assign w_cyc = w_vld && w_rdy;
    assign r_cyc = r_vld && r_rdy;

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    always_comb begin
        level_nxt = level
                  + {{AW{1'b0}}, w_cyc}
                  - {{AW{1'b0}}, r_cyc};
        if (flush) level_nxt = '0;
    end

    assign almost_full  = (level >= LW'(AFULL_TH));
    assign almost_empty = (level <= LW'(AEMPTY_TH));

    always_ff @(posedge axis_clk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            max_level <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            max_level <= '0;
        end else begin
            if (w_cyc) wr_ptr <= wr_ptr + 1'b1;
            if (r_cyc) rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            if (level_nxt > max_level) max_level <= level_nxt;
        end
    end

endmodule

// File: rtl/axis_fifo_param.sv
// Parametrised first-word-fall-through valid/ready FIFO on a flop array.
module axis_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int AW        = clog2(DEPTH),
    parameter int LW        = AW + 1
) (
    input  logic             axis_clk,
    input  logic             axi_reset,
    input  logic             flush,
    input  logic             w_vld,
    output logic             w_rdy,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_rdy,
    output logic             r_vld,
    output logic [WIDTH-1:0] data_out,
    output logic [LW-1:0]    level,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    max_level
);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_fifo_param: DEPTH must be a power of 2 in 2..256");
    end
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("axis_fifo_param: AFULL_TH exceeds DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("axis_fifo_param: AEMPTY_TH must be below DEPTH");
    end
    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
        $error("axis_fifo_param: WIDTH must be in 1..256");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic             w_cyc;
    logic             r_cyc;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH),
        .AW        (AW),
        .LW        (LW)
    ) u_ctrl (
        .axis_clk     (axis_clk),
        .axi_reset    (axi_reset),
        .flush        (flush),
        .w_vld        (w_vld),
        .r_rdy        (r_rdy),
        .w_rdy        (w_rdy),
        .r_vld        (r_vld),
        .w_cyc        (w_cyc),
        .r_cyc        (r_cyc),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_level    (max_level)
    );

    // Storage is deliberately unreset; the output mask hides stale entries.
    always_ff @(posedge axis_clk) begin
        if (w_cyc) mem[wr_addr] <= data_in;
    end

    assign data_out = r_vld ? mem[rd_addr] : '0;

    logic unused_r_cyc;
    assign unused_r_cyc = r_cyc;

endmodule

// File: tb/tb_axis_fifo_param.sv
// Randomised self-checking bench for axis_fifo_param against a queue model.
module tb_axis_fifo_param;

    localparam int WIDTH = 45;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 2;

    logic             axis_clk = 1'b0;
    logic             axi_reset = 1'b1;
    logic             flush = 1'b0;
    logic             w_vld = 1'b0;
    logic             w_rdy;
    logic [WIDTH-1:0] data_in = '0;
    logic             r_rdy = 1'b0;
    logic             r_vld;
    logic [WIDTH-1:0] data_out;
    logic [LW-1:0]    level;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    max_level;

    axis_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .axis_clk     (axis_clk),
        .axi_reset    (axi_reset),
        .flush        (flush),
        .w_vld        (w_vld),
        .w_rdy        (w_rdy),
        .data_in      (data_in),
        .r_rdy        (r_rdy),
        .r_vld        (r_vld),
        .data_out     (data_out),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_level    (max_level)
    );

    always #5 axis_clk = ~axis_clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    logic [WIDTH-1:0] q[$];
    int               m_max = 0;

    always @(negedge axis_clk) begin
        int  n;
        bit  ew;
        bit  er;
        if (axi_reset) begin
            q.delete();
            m_max = 0;
        end
        n  = q.size();
        ew = (n < DEPTH) && !flush;
        er = (n > 0) && !flush;
        check("w_rdy", {63'd0, w_rdy}, {63'd0, ew});
        check("r_vld", {63'd0, r_vld}, {63'd0, er});
        check("level", 64'(level), 64'(n));
        check("max_level", 64'(max_level), 64'(m_max));
        check("almost_full", {63'd0, almost_full}, {63'd0, n >= AFT});
        check("almost_empty", {63'd0, almost_empty}, {63'd0, n <= AET});
        check("data_out", 64'(data_out), er ? 64'(q[0]) : 64'd0);
        if (!axi_reset) begin
            if (flush) begin
                q.delete();
                m_max = 0;
            end else begin
                if (er && r_rdy) void'(q.pop_front());
                if (ew && w_vld) q.push_back(data_in);
                if (q.size() > m_max) m_max = q.size();
            end
        end
    end

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic write_n(input int n, input int base);
        w_vld = 1'b1;
        r_rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = WIDTH'(base + i);
            step();
        end
        w_vld = 1'b0;
    endtask

    task automatic drain_all();
        w_vld = 1'b0;
        r_rdy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        r_rdy = 1'b0;
    endtask

    initial begin
        int wr_cnt;
        int rd_cnt;
        int cyc;
        repeat (3) @(posedge axis_clk);
        #1 axi_reset = 1'b0;
        step();

        w_vld = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            data_in = WIDTH'(i);
            step();
            check("fill_w_rdy", {63'd0, w_rdy}, {63'd0, i < DEPTH});
            check("fill_afull", {63'd0, almost_full}, {63'd0, i >= 14});
        end
        w_vld = 1'b0;
        check("fill_level", 64'(level), 64'd16);
        check("fill_max", 64'(max_level), 64'd16);

        r_rdy = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_vld", {63'd0, r_vld}, 64'd1);
            check("drain_data", 64'(data_out), 64'(i));
            step();
        end
        r_rdy = 1'b0;
        check("drained_vld", {63'd0, r_vld}, 64'd0);
        check("drained_level", 64'(level), 64'd0);
        check("drained_aempty", {63'd0, almost_empty}, 64'd1);

        wr_cnt = 0;
        rd_cnt = 0;
        cyc = 0;
        while ((wr_cnt < 100 || rd_cnt < 100) && cyc < 3000) begin
            w_vld   = (wr_cnt < 100) && ($urandom_range(0, 1) == 1);
            r_rdy   = ($urandom_range(0, 1) == 1);
            data_in = {$urandom, $urandom};
            #1;
            if (w_vld && w_rdy) wr_cnt++;
            if (r_vld && r_rdy) rd_cnt++;
            @(posedge axis_clk);
            #1;
            cyc++;
        end
        check("stream_done", 64'(rd_cnt), 64'd100);
        w_vld = 1'b0;
        r_rdy = 1'b0;
        step();
        check("stream_level", 64'(level), 64'd0);

        write_n(DEPTH, 32'h100);
        check("full_level", 64'(level), 64'd16);
        w_vld = 1'b1;
        r_rdy = 1'b1;
        data_in = 'h1AA;
        step();
        check("full_rd_only", 64'(level), 64'd15);
        data_in = 'h1BB;
        step();
        check("both_fire", 64'(level), 64'd15);
        drain_all();

        flush = 1'b1;
        step();
        flush = 1'b0;
        write_n(12, 32'h200);
        r_rdy = 1'b1;
        repeat (3) step();
        r_rdy = 1'b0;
        check("pre_flush_level", 64'(level), 64'd9);
        check("pre_flush_max", 64'(max_level), 64'd12);
        flush = 1'b1;
        w_vld = 1'b1;
        data_in = 'h2FF;
        #1;
        check("flush_w_rdy", {63'd0, w_rdy}, 64'd0);
        check("flush_r_vld", {63'd0, r_vld}, 64'd0);
        @(posedge axis_clk);
        #1;
        flush = 1'b0;
        w_vld = 1'b0;
        check("post_flush_level", 64'(level), 64'd0);
        check("post_flush_max", 64'(max_level), 64'd0);
        check("post_flush_vld", {63'd0, r_vld}, 64'd0);

        write_n(5, 32'h300);
        check("prerst_level", 64'(level), 64'd5);
        #1 axi_reset = 1'b1;
        #1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_max", 64'(max_level), 64'd0);
        check("rst_vld", {63'd0, r_vld}, 64'd0);
        check("rst_wrdy", {63'd0, w_rdy}, 64'd1);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_aempty", {63'd0, almost_empty}, 64'd1);
        check("rst_afull", {63'd0, almost_full}, 64'd0);
        step();
        axi_reset = 1'b0;
        step();
        w_vld = 1'b1;
        data_in = 'h1234;
        step();
        w_vld = 1'b0;
        check("first_after_rst_vld", {63'd0, r_vld}, 64'd1);
        check("first_after_rst_data", 64'(data_out), 64'h1234);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
